// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures one byte per rising edge of rx_done_sig and holds it until a consumer pops it.
// Build option UART_RX_FIFO_FWFT_EN: first-word-fall-through read port (head byte shown
// combinationally). Default: rd_data is registered on each pop with a one-cycle rd_valid.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done_sig,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              underrun
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              done_q, done_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic wr_req;
  logic rd_ok;
  logic wr_ok;

  // Next-state logic: edge-detect the receiver strobe, arbitrate push/pop, track level and errors.
  always_comb begin
    wr_req     = rx_done_sig & ~done_q;
    rd_ok      = rd_en & ~empty_q;
    wr_ok      = wr_req & (~full_q | rd_ok);
    done_d     = rx_done_sig;
    wr_ptr_d   = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d    = (count_d == '0);
    full_d     = (count_d == FULL_COUNT);
    overrun_d  = overrun_q;
    if (wr_req && !wr_ok) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
    underrun_d = underrun_q;
    if (rd_en && empty_q) begin
      underrun_d = 1'b1;
    end else if (clr_err) begin
      underrun_d = 1'b0;
    end
  end

  // Control and status registers; reset discards every stored entry and clears the flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Byte storage, written only on accepted pushes and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign rd_data  = empty_q ? '0 : mem[rd_ptr_q];
  assign rd_valid = ~empty_q;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Popped byte is captured on the read edge and flagged valid for exactly the next cycle.
  always_comb begin
    rd_data_d  = rd_ok ? mem[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_ok;
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (default or FWFT build).
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] rx_data;
  logic              rx_done_sig;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              underrun;

  int num_checks = 0;
  int num_errors = 0;

  // Reference model: a queue of stored bytes plus the sticky flags and last popped byte.
  logic [7:0] m_q[$];
  logic       m_prev_done;
  logic       m_ovr;
  logic       m_unr;
  logic       m_valid;
  logic [7:0] m_data;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovr;
    logic       unr;
    logic       vld;
    logic [7:0] dout;
    logic [7:0] head;
  } vec_t;

  vec_t tbl [18];

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_done_sig(rx_done_sig),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .underrun   (underrun)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev_done = 1'b0;
    m_ovr       = 1'b0;
    m_unr       = 1'b0;
    m_valid     = 1'b0;
    m_data      = 8'h00;
  endtask

  task automatic model_step(input logic done, input logic [7:0] data, input logic rd,
                            input logic clr);
    bit         wr_req;
    bit         rd_ok;
    bit         accept;
    logic [7:0] popped;
    popped = 8'h00;
    wr_req = done && !m_prev_done;
    rd_ok  = rd && (m_q.size() != 0);
    accept = wr_req && ((m_q.size() < DEPTH) || rd_ok);
    if (rd_ok) popped = m_q.pop_front();
    if (accept) m_q.push_back(data);
    m_valid = rd_ok;
    if (rd_ok) m_data = popped;
    if (wr_req && !accept) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (rd && !rd_ok) m_unr = 1'b1;
    else if (clr) m_unr = 1'b0;
    m_prev_done = done;
  endtask

  task automatic check_output();
    chk("count", 32'(count), 32'(m_q.size()));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("underrun", 32'(underrun), 32'(m_unr));
`ifdef UART_RX_FIFO_FWFT_EN
    chk("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
    chk("rd_data", 32'(rd_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
`else
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_data));
`endif
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, then compare.
  task automatic apply_stimulus(input logic done, input logic [7:0] data, input logic rd,
                                input logic clr);
    rx_done_sig = done;
    rx_data     = data;
    rd_en       = rd;
    clr_err     = clr;
    @(posedge clk);
    model_step(done, data, rd, clr);
    #1;
    check_output();
  endtask

  task automatic write_byte(input logic [7:0] b);
    apply_stimulus(1'b1, b, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    rx_done_sig = 1'b0;
    rx_data     = 8'h00;
    rd_en       = 1'b0;
    clr_err     = 1'b0;
    model_reset();

    // Reset held while the receiver strobe toggles: everything stays cleared.
    for (int i = 0; i < 6; i++) begin
      rx_done_sig = i[0];
      rx_data     = 8'hA0 + 8'(i);
      rd_en       = i[1];
      @(posedge clk);
      #1;
      check_output();
    end
    rx_done_sig = 1'b0;
    rd_en       = 1'b0;
    rst         = 1'b0;

    // Ordered writes, reads, level strobe, underrun on empty and error clear.
    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55};
    tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55};
    tbl[4]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8'hA3};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 8'h0F};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h00};
    tbl[9]  = '{1'b1, 8'h7E, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h7E};
    tbl[10] = '{1'b1, 8'h7E, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h7E};
    tbl[11] = '{1'b1, 8'h7E, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h7E};
    tbl[12] = '{1'b1, 8'h7E, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h7E};
    tbl[13] = '{1'b1, 8'h7E, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h7E};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'h7E};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, 8'h00};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7E, 8'h00};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7E, 8'h00};

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(tbl[i].done, tbl[i].data, tbl[i].rd, tbl[i].clr);
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].emp));
      chk("tbl_full", 32'(full), 32'(tbl[i].ful));
      chk("tbl_overrun", 32'(overrun), 32'(tbl[i].ovr));
      chk("tbl_underrun", 32'(underrun), 32'(tbl[i].unr));
`ifdef UART_RX_FIFO_FWFT_EN
      chk("tbl_rd_valid", 32'(rd_valid), 32'(!tbl[i].emp));
      chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].head));
`else
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].vld));
      chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].dout));
`endif
    end

    // Fill past capacity: the 17th byte is dropped and overrun latches.
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(i));
      if (i == 15) chk("full_after_16", 32'(full), 32'h1);
    end
    chk("overrun_after_17", 32'(overrun), 32'h1);
    chk("count_after_17", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
`ifdef UART_RX_FIFO_FWFT_EN
      chk("full_read_order", 32'(rd_data), 32'(i));
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
`else
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
      chk("full_read_order", 32'(rd_data), 32'(i));
`endif
    end
    chk("empty_after_drain", 32'(empty), 32'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    chk("overrun_cleared", 32'(overrun), 32'h0);

    // Push and pop on the same edge while full: both succeed, nothing dropped.
    for (int i = 0; i < 16; i++) write_byte(8'hB0 + 8'(i));
    apply_stimulus(1'b1, 8'hC3, 1'b1, 1'b0);
    chk("simul_count", 32'(count), 32'd16);
    chk("simul_overrun", 32'(overrun), 32'h0);
    for (int i = 1; i <= 16; i++) begin
`ifdef UART_RX_FIFO_FWFT_EN
      if (i == 16) chk("simul_16th_read", 32'(rd_data), 32'hC3);
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
`else
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 16) chk("simul_16th_read", 32'(rd_data), 32'hC3);
`endif
    end

    // Underrun, then write/read pairs carrying random bytes across the pointer wrap.
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underrun_set", 32'(underrun), 32'h1);
    chk("underrun_count", 32'(count), 32'h0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Random traffic: a write-heavy phase to reach full, then a read-heavy phase.
    for (int i = 0; i < 400; i++) begin
      logic d;
      logic r;
      logic c;
      d = ($urandom_range(0, 2) != 0);
      r = (i < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      apply_stimulus(d, 8'($urandom), r, c);
    end

    // Asynchronous reset mid-operation: contents and flags vanish without a clock edge.
    for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i));
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_output();
    chk("async_rst_count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    check_output();
    rst = 1'b0;
    write_byte(8'h99);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
